// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Bimodal branch-history table. A table of 2-bit saturating counters is
// indexed by the decode-stage PC and gives a combinational taken/not-taken
// prediction for conditional branches (opcode BRANCH). One cycle later the
// same entry is trained with the execute-stage outcome.
//
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
// There are no tags, so PCs equal modulo 4*ENTRIES share an entry.
//
// Optional feature macro: BP_STATS_EN
//   defined   -> branch / mispredict statistics counters and stats clear
//   undefined -> statistics outputs tied to 0, i_stats_clr ignored
//
// Ports:
//   i_clk               clock, all state on rising edge
//   i_rst_n             asynchronous active-low reset
//   i_decode_pc[31:0]   PC of the instruction in decode
//   i_decode_inst[31:0] instruction in decode
//   o_predict           1 = predict taken for the decode-stage instruction
//   i_pred_en           execute-stage valid conditional branch, train now
//   i_result            resolved outcome of that branch (1 = taken)
//   i_stats_clr         synchronous clear of the statistics counters
//   o_branch_count      trained branches since reset/clear
//   o_mispredict_count  trained branches whose prediction differed from result
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_decode_pc,
    input  logic [31:0] i_decode_inst,
    output logic        o_predict,
    input  logic        i_pred_en,
    input  logic        i_result,
    input  logic        i_stats_clr,
    output logic [31:0] o_branch_count,
    output logic [31:0] o_mispredict_count
);

    localparam int IDX = $clog2(ENTRIES);

    logic [IDX-1:0] w_idx;
    logic [IDX-1:0] r_idx_q;
    logic [1:0]     r_ctr [ENTRIES];
    logic           w_is_branch;
    logic [1:0]     w_ctr_rd;
    logic [1:0]     w_ctr_cur;
    logic [1:0]     w_ctr_next;
    logic           w_unused;

    // Word-aligned PC bits select the entry; only the BRANCH major opcode
    // (inst[6:2] = 11000) may predict taken, so JAL/JALR always give 0.
    assign w_idx       = i_decode_pc[IDX+1:2];
    assign w_is_branch = (i_decode_inst[6:2] == 5'b11000);
    assign w_ctr_rd    = r_ctr[w_idx];
    assign o_predict   = w_is_branch & w_ctr_rd[1];

    // Saturating update of the entry looked up one cycle earlier.
    assign w_ctr_cur = r_ctr[r_idx_q];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (i_result) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
        end
    end

    // Table and index pipeline register. The write lands on the clock edge,
    // so a same-cycle read of the same entry sees the old value (no bypass).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else begin
            r_idx_q <= w_idx;
            if (i_pred_en) begin
                r_ctr[r_idx_q] <= w_ctr_next;
            end
        end
    end

`ifdef BP_STATS_EN
    logic        r_pred_q;
    logic [31:0] r_branch_count;
    logic [31:0] r_mispredict_count;

    // Statistics: the prediction made in decode is carried along so the
    // execute-stage outcome can be compared against it. Clear wins over count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pred_q           <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_pred_q <= o_predict;
            if (i_stats_clr) begin
                r_branch_count     <= '0;
                r_mispredict_count <= '0;
            end else if (i_pred_en) begin
                r_branch_count <= r_branch_count + 32'd1;
                if (r_pred_q ^ i_result) begin
                    r_mispredict_count <= r_mispredict_count + 32'd1;
                end
            end
        end
    end

    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

    assign w_unused = ^{i_decode_pc[31:IDX+2], i_decode_pc[1:0],
                        i_decode_inst[31:7], i_decode_inst[1:0]};
`else
    assign o_branch_count     = 32'd0;
    assign o_mispredict_count = 32'd0;

    assign w_unused = ^{i_decode_pc[31:IDX+2], i_decode_pc[1:0],
                        i_decode_inst[31:7], i_decode_inst[1:0], i_stats_clr};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed self-checking bench for branch_predictor (ENTRIES = 64).
// Expected statistics values are zero when BP_STATS_EN is not defined.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int          ENTRIES = 64;
    localparam logic [31:0] BEQ     = 32'h0000_0063;
    localparam logic [31:0] BNE     = 32'h0000_1063;
    localparam logic [31:0] ADDI    = 32'h0000_0013;
    localparam logic [31:0] JAL     = 32'h0000_006F;
    localparam logic [31:0] NOP     = 32'h0000_0000;

`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] decodePc;
    logic [31:0] decodeInst;
    logic        predict;
    logic        predEn;
    logic        result;
    logic        statsClr;
    logic [31:0] branchCount;
    logic [31:0] mispredictCount;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .i_clk              (clk),
        .i_rst_n            (rstN),
        .i_decode_pc        (decodePc),
        .i_decode_inst      (decodeInst),
        .o_predict          (predict),
        .i_pred_en          (predEn),
        .i_result           (result),
        .i_stats_clr        (statsClr),
        .o_branch_count     (branchCount),
        .o_mispredict_count (mispredictCount)
    );

    function automatic logic [31:0] expCount(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                         input logic en, input logic res);
        decodePc   = pc;
        decodeInst = inst;
        predEn     = en;
        result     = res;
    endtask

    // One branch instance: decode cycle, then the training cycle.
    task automatic runBranch(input logic [31:0] pc, input logic [31:0] inst,
                             input logic taken, output logic observed);
        drive(pc, inst, 1'b0, 1'b0);
        #1;
        observed = predict;
        tick();
        drive(32'h0, NOP, 1'b1, taken);
        tick();
        drive(32'h0, NOP, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rstN     = 1'b0;
        statsClr = 1'b0;
        drive(32'h100, BEQ, 1'b0, 1'b0);
        #2;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_predict: got %b want 0", predict);
        end
        vectors++;
        if (branchCount !== 32'd0 || mispredictCount !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", branchCount, mispredictCount);
        end
        tick();
        tick();
        rstN = 1'b1;
        drive(32'h0, NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_cold_read();
        drive(32'h100, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL cold_read: got %b want 0", predict);
        end
        drive(32'h0, NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_training();
        logic obs;
        runBranch(32'h100, BEQ, 1'b1, obs);
        vectors++;
        if (obs !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL train_first: got %b want 0", obs);
        end
        runBranch(32'h100, BEQ, 1'b1, obs);
        vectors++;
        if (obs !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL train_second: got %b want 1", obs);
        end
        drive(32'h100, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL train_lookup: got %b want 1", predict);
        end
        vectors++;
        if (branchCount !== expCount(2) || mispredictCount !== expCount(1)) begin
            miscompares++;
            $display("[TB] FAIL train_counts: got %0d/%0d want %0d/%0d",
                     branchCount, mispredictCount, expCount(2), expCount(1));
        end
        drive(32'h0, NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_saturation();
        logic obs;
        for (int i = 0; i < 3; i++) begin
            runBranch(32'h100, BEQ, 1'b1, obs);
            vectors++;
            if (obs !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL sat_taken%0d: got %b want 1", i, obs);
            end
        end
        runBranch(32'h100, BEQ, 1'b0, obs);
        drive(32'h100, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_first_nt: got %b want 1", predict);
        end
        runBranch(32'h100, BEQ, 1'b0, obs);
        drive(32'h100, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sat_second_nt: got %b want 0", predict);
        end
        vectors++;
        if (branchCount !== expCount(7) || mispredictCount !== expCount(3)) begin
            miscompares++;
            $display("[TB] FAIL sat_counts: got %0d/%0d want %0d/%0d",
                     branchCount, mispredictCount, expCount(7), expCount(3));
        end
        drive(32'h0, NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_gating_alias();
        logic obs;
        runBranch(32'h100, BEQ, 1'b1, obs);
        runBranch(32'h100, BEQ, 1'b1, obs);
        drive(32'h100, ADDI, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL gate_addi: got %b want 0", predict);
        end
        drive(32'h100, JAL, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL gate_jal: got %b want 0", predict);
        end
        drive(32'h200, BNE, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL alias_bne: got %b want 1", predict);
        end
        drive(32'h104, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL neighbour_entry: got %b want 0", predict);
        end
        drive(32'h0, NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_same_cycle();
        drive(32'h104, BEQ, 1'b0, 1'b0);
        tick();
        drive(32'h104, BEQ, 1'b1, 1'b1);
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_old: got %b want 0", predict);
        end
        tick();
        drive(32'h104, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_new: got %b want 1", predict);
        end
        vectors++;
        if (branchCount !== expCount(10) || mispredictCount !== expCount(5)) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_counts: got %0d/%0d want %0d/%0d",
                     branchCount, mispredictCount, expCount(10), expCount(5));
        end
        drive(32'h108, NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_stats_clr();
        drive(32'h108, NOP, 1'b1, 1'b1);
        statsClr = 1'b1;
        tick();
        statsClr = 1'b0;
        vectors++;
        if (branchCount !== 32'd0 || mispredictCount !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL clr_priority: got %0d/%0d want 0/0", branchCount, mispredictCount);
        end
        drive(32'h108, NOP, 1'b1, 1'b0);
        tick();
        vectors++;
        if (branchCount !== expCount(1) || mispredictCount !== expCount(0)) begin
            miscompares++;
            $display("[TB] FAIL clr_recount: got %0d/%0d want %0d/%0d",
                     branchCount, mispredictCount, expCount(1), expCount(0));
        end
        drive(32'h0, NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(32'h100, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_predict: got %b want 1", predict);
        end
        #2;
        rstN = 1'b0;
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_predict: got %b want 0", predict);
        end
        vectors++;
        if (branchCount !== 32'd0 || mispredictCount !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL async_counts: got %0d/%0d want 0/0", branchCount, mispredictCount);
        end
        drive(32'h100, BEQ, 1'b1, 1'b1);
        tick();
        tick();
        drive(32'h100, BEQ, 1'b0, 1'b0);
        rstN = 1'b1;
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_entry0: got %b want 0", predict);
        end
        drive(32'h104, BEQ, 1'b0, 1'b0);
        #1;
        vectors++;
        if (predict !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_entry1: got %b want 0", predict);
        end
        tick();
        vectors++;
        if (branchCount !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_count: got %0d want 0", branchCount);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_training();
        test_saturation();
        test_gating_alias();
        test_same_cycle();
        test_stats_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
